// File: rtl/reg_file.sv
// Architectural register file: one partial-width write port, two registered read ports,
// and a per-register pending-write scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module reg_file_entry #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_hit,
  input  logic [1:0]       w_mode,
  input  logic [WIDTH-1:0] data,
  input  logic             set_hit,
  output logic [WIDTH-1:0] rd_val,
  output logic             busy_rd
);
  logic [WIDTH-1:0] q, merged, q_nxt;
  logic             busy;

  always_comb begin
    merged = q;
    case (w_mode)
      2'd0:    merged = data;
      2'd1:    merged[15:0] = data[15:0];
      2'd2:    merged[7:0] = data[7:0];
      default: merged = q;
    endcase
  end

  assign q_nxt   = wr_hit ? merged : q;
  assign rd_val  = BYPASS ? q_nxt : q;
  // Any write retires the pending destination; the read sees the cleared state.
  assign busy_rd = busy & ~wr_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      q    <= q_nxt;
      busy <= set_hit | busy_rd;
    end
  end
endmodule

module reg_file #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int NUM_REGS     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [REG_ADDR_LEN-1:0] Addr,
  input  logic [WIDTH-1:0]        Data,
  input  logic [1:0]              w_mode,
  input  logic                    rd_en,
  input  logic [REG_ADDR_LEN-1:0] rd_addr_a,
  input  logic [REG_ADDR_LEN-1:0] rd_addr_b,
  output logic [WIDTH-1:0]        rd_data_a,
  output logic [WIDTH-1:0]        rd_data_b,
  input  logic                    busy_set_en,
  input  logic [REG_ADDR_LEN-1:0] busy_set_addr,
  output logic                    busy_a,
  output logic                    busy_b,
  output logic                    wmode_err
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic                    en;
    logic [REG_ADDR_LEN-1:0] addr;
    logic [WIDTH-1:0]        data;
    logic [1:0]              mode;
  } wr_req_t;

  wr_req_t wr;
  assign wr = '{en: wr_en, addr: Addr, data: Data, mode: w_mode};

  logic [NUM_REGS-1:0][WIDTH-1:0] rd_val;
  logic [NUM_REGS-1:0]            busy_rd;
  logic [NUM_REGS-1:0]            wr_hit, set_hit;

  genvar i;
  generate
    for (i = 0; i < NUM_REGS; i++) begin : g_reg
      if (i == 0) begin : g_zero
        // r0 is hardwired: no storage, never busy.
        assign wr_hit[i]  = 1'b0;
        assign set_hit[i] = 1'b0;
        assign rd_val[i]  = '0;
        assign busy_rd[i] = 1'b0;
      end else begin : g_ent
        assign wr_hit[i]  = wr.en && (wr.addr == REG_ADDR_LEN'(i));
        assign set_hit[i] = busy_set_en && (busy_set_addr == REG_ADDR_LEN'(i));
        reg_file_entry #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_ent (
          .clk     (clk),
          .rst     (rst),
          .wr_hit  (wr_hit[i]),
          .w_mode  (wr.mode),
          .data    (wr.data),
          .set_hit (set_hit[i]),
          .rd_val  (rd_val[i]),
          .busy_rd (busy_rd[i])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      busy_a    <= 1'b0;
      busy_b    <= 1'b0;
    end else if (rd_en) begin
      rd_data_a <= rd_val[rd_addr_a];
      rd_data_b <= rd_val[rd_addr_b];
      busy_a    <= busy_rd[rd_addr_a];
      busy_b    <= busy_rd[rd_addr_b];
    end
  end

  // Reserved-mode writes to r0 are dropped like any other r0 write, so they do not flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wmode_err <= 1'b0;
    else     wmode_err <= wr.en && (wr.mode == 2'd3) && (wr.addr != '0);
  end
endmodule

// File: tb/tb_reg_file.sv
// Directed + random bench for reg_file against an array-based architectural model.
module tb_reg_file;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  Addr = '0;
  logic [31:0] Data = '0;
  logic [1:0]  w_mode = '0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_addr_a = '0, rd_addr_b = '0;
  logic [31:0] rd_data_a, rd_data_b;
  logic        busy_set_en = 1'b0;
  logic [4:0]  busy_set_addr = '0;
  logic        busy_a, busy_b, wmode_err;

  reg_file dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .Addr(Addr), .Data(Data), .w_mode(w_mode),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
    .busy_a(busy_a), .busy_b(busy_b), .wmode_err(wmode_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl [32];
  bit          mbusy [32];
  logic [31:0] exp_a = '0, exp_b = '0;
  logic        exp_ba = 1'b0, exp_bb = 1'b0, exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin
      mdl[k]   = '0;
      mbusy[k] = 1'b0;
    end
    exp_a = '0; exp_b = '0; exp_ba = 1'b0; exp_bb = 1'b0; exp_err = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] m);
    case (m)
      2'd0:    return d;
      2'd1:    return (old & 32'hFFFF_0000) | (d & 32'h0000_FFFF);
      2'd2:    return (old & 32'hFFFF_FF00) | (d & 32'h0000_00FF);
      default: return old;
    endcase
  endfunction

  // One clock: drive, predict architecturally, clock, then compare all outputs.
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [1:0] wm, input logic re, input logic [4:0] ra,
                      input logic [4:0] rb, input logic se, input logic [4:0] sa);
    logic [31:0] nxt [32];
    wr_en = we; Addr = wa; Data = wd; w_mode = wm;
    rd_en = re; rd_addr_a = ra; rd_addr_b = rb;
    busy_set_en = se; busy_set_addr = sa;
    for (int k = 0; k < 32; k++) nxt[k] = mdl[k];
    if (we && wa != 0) nxt[wa] = merge(mdl[wa], wd, wm);
    if (re) begin
      exp_a  = BYP ? nxt[ra] : mdl[ra];
      exp_b  = BYP ? nxt[rb] : mdl[rb];
      exp_ba = mbusy[ra] && !(we && wa == ra);
      exp_bb = mbusy[rb] && !(we && wb_eq(wa, rb));
    end
    exp_err = we && wm == 2'd3 && wa != 0;
    for (int k = 0; k < 32; k++) mdl[k] = nxt[k];
    if (we) mbusy[wa] = 1'b0;
    if (se && sa != 0) mbusy[sa] = 1'b1;
    @(posedge clk);
    #1;
    chk("rd_data_a", rd_data_a, exp_a);
    chk("rd_data_b", rd_data_b, exp_b);
    chk("busy_a", {31'b0, busy_a}, {31'b0, exp_ba});
    chk("busy_b", {31'b0, busy_b}, {31'b0, exp_bb});
    chk("wmode_err", {31'b0, wmode_err}, {31'b0, exp_err});
  endtask

  function automatic bit wb_eq(input logic [4:0] x, input logic [4:0] y);
    return x == y;
  endfunction

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [1:0] m);
    step(1'b1, a, d, m, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    step(1'b0, 5'd0, 32'd0, 2'd0, 1'b1, a, b, 1'b0, 5'd0);
  endtask

  initial begin
    model_reset();
    #12 rst = 1'b0;
    chk("reset_rd_a", rd_data_a, 32'h0);
    chk("reset_busy_a", {31'b0, busy_a}, 32'h0);
    chk("reset_err", {31'b0, wmode_err}, 32'h0);

    // Async reset clears state without a clock edge and drops an in-flight write.
    wr(5'd5, 32'hDEAD_BEEF, 2'd0);
    step(1'b0, 5'd0, 32'd0, 2'd0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd5);
    chk("pre_reset_r5", rd_data_a, 32'hDEAD_BEEF);
    step(1'b1, 5'd7, 32'd0, 2'd3, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0);
    #3;
    wr_en = 1'b1; Addr = 5'd5; Data = 32'h1234_5678; w_mode = 2'd0; rd_en = 1'b1;
    rst = 1'b1;
    #1;
    chk("async_rst_rd_a", rd_data_a, 32'h0);
    chk("async_rst_busy_a", {31'b0, busy_a}, 32'h0);
    chk("async_rst_err", {31'b0, wmode_err}, 32'h0);
    @(posedge clk);
    #1 wr_en = 1'b0; rd_en = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    rd(5'd5, 5'd5);
    chk("r5_after_reset", rd_data_a, 32'h0);

    // Partial writes.
    wr(5'd3, 32'h1122_3344, 2'd0); rd(5'd3, 5'd0);
    chk("word_r3", rd_data_a, 32'h1122_3344);
    wr(5'd3, 32'hAAAA_5555, 2'd1); rd(5'd3, 5'd0);
    chk("half_r3", rd_data_a, 32'h1122_5555);
    wr(5'd3, 32'h0000_00EE, 2'd2); rd(5'd3, 5'd0);
    chk("byte_r3", rd_data_a, 32'h1122_55EE);

    // r0 and reserved mode.
    wr(5'd0, 32'hFFFF_FFFF, 2'd0); rd(5'd0, 5'd0);
    chk("r0_zero", rd_data_a, 32'h0);
    wr(5'd7, 32'hCAFE_F00D, 2'd0);
    wr(5'd7, 32'h5555_5555, 2'd3);
    chk("err_pulse", {31'b0, wmode_err}, 32'h1);
    rd(5'd7, 5'd0);
    chk("err_drop", {31'b0, wmode_err}, 32'h0);
    chk("r7_kept", rd_data_a, 32'hCAFE_F00D);

    // JAL-style writeback of r31 while decode reads it.
    wr(5'd31, 32'h1234_5678, 2'd0);
    step(1'b1, 5'd31, 32'h0040_0010, 2'd0, 1'b1, 5'd0, 5'd31, 1'b0, 5'd0);
    chk("jal_same_cycle", rd_data_b, BYP ? 32'h0040_0010 : 32'h1234_5678);
    rd(5'd0, 5'd31);
    chk("jal_next_read", rd_data_b, 32'h0040_0010);

    // Scoreboard.
    step(1'b0, 5'd0, 32'd0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd9);
    rd(5'd9, 5'd0);
    chk("busy_r9", {31'b0, busy_a}, 32'h1);
    step(1'b1, 5'd9, 32'h0000_0099, 2'd0, 1'b1, 5'd9, 5'd0, 1'b0, 5'd0);
    chk("busy_r9_cleared", {31'b0, busy_a}, 32'h0);
    step(1'b1, 5'd9, 32'h0000_0100, 2'd2, 1'b0, 5'd0, 5'd0, 1'b1, 5'd9);
    rd(5'd9, 5'd9);
    chk("set_wins", {31'b0, busy_a}, 32'h1);
    step(1'b0, 5'd0, 32'd0, 2'd0, 1'b1, 5'd4, 5'd0, 1'b1, 5'd4);
    chk("set_same_cycle_prior", {31'b0, busy_a}, 32'h0);
    step(1'b0, 5'd0, 32'd0, 2'd0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0);
    chk("r0_never_busy", {31'b0, busy_a}, 32'h0);

    // Dual port on the same address.
    wr(5'd12, 32'h0000_BEEF, 2'd0);
    rd(5'd12, 5'd12);
    chk("dual_a", rd_data_a, 32'h0000_BEEF);
    chk("dual_b", rd_data_b, 32'h0000_BEEF);
    chk("dual_busy_eq", {31'b0, busy_a}, {31'b0, busy_b});

    // Random traffic on a narrow address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)), $urandom,
           2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
